// File: rtl/div_unit_iter_pkg.sv
// Shared core definitions for the iterative divider: op encodings (also used by
// the decoder), FSM state type and the default datapath width.
package div_unit_iter_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep the result if it fits.
module div_step
    import div_unit_iter_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_div,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);

    // One extra bit so the shifted remainder and the borrow both fit.
    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_diff;
    logic          w_fits;

    assign w_shift = {i_rem, i_quo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, i_div};
    assign w_fits  = ~w_diff[XLEN];

    assign o_rem = w_fits ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
    assign o_quo = {i_quo[XLEN-2:0], w_fits};

endmodule

// File: rtl/div_unit_iter.sv
// Iterative radix-2 divider for RV32M DIV/DIVU/REM/REMU in the EXE stage;
// stalls the front of the pipe while busy and pulses done with the result.
module div_unit_iter
    import div_unit_iter_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      rd_in,
    input  logic            kill,
    output logic            stall_req,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam int unsigned CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;

    div_state_t      r_state;
    div_state_t      w_state_nxt;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_div;
    logic [XLEN-1:0] r_result;
    logic [CNT_W-1:0] r_cnt;
    logic            r_sign_q;
    logic            r_sign_r;
    logic            r_is_rem;
    logic            r_done;
    logic [4:0]      r_rd;

    logic            w_accept;
    logic            w_signed;
    logic            w_div_zero;
    logic            w_ovf;
    logic            w_special;
    logic            w_last;
    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;
    logic [XLEN-1:0] w_spec_res;
    logic [XLEN-1:0] w_step_rem;
    logic [XLEN-1:0] w_step_quo;
    logic [XLEN-1:0] w_quo_fin;
    logic [XLEN-1:0] w_rem_fin;

    assign w_accept   = (r_state == DIV_IDLE) && start && !kill;
    assign w_signed   = op_is_signed(op);
    assign w_div_zero = (b == '0);
    assign w_ovf      = w_signed && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    assign w_special  = w_div_zero || w_ovf;
    assign w_last     = (r_cnt == '0);

    assign w_abs_a = (w_signed && a[XLEN-1]) ? -a : a;
    assign w_abs_b = (w_signed && b[XLEN-1]) ? -b : b;

    // Zero divisor: q = all ones, r = a. Signed overflow: q = a, r = 0.
    assign w_spec_res = op_is_rem(op) ? (w_div_zero ? a : '0)
                                      : (w_div_zero ? '1 : a);

    div_step #(.XLEN(XLEN)) u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_div (r_div),
        .o_rem (w_step_rem),
        .o_quo (w_step_quo)
    );

    assign w_quo_fin = r_sign_q ? -w_step_quo : w_step_quo;
    assign w_rem_fin = r_sign_r ? -w_step_rem : w_step_rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            DIV_IDLE: if (start) w_state_nxt = w_special ? DIV_DONE : DIV_BUSY;
            DIV_BUSY: if (w_last) w_state_nxt = DIV_DONE;
            DIV_DONE: w_state_nxt = DIV_IDLE;
            default:  w_state_nxt = DIV_IDLE;
        endcase
        if (kill) w_state_nxt = DIV_IDLE;
    end

    // Combinational so ID/EX is held in the very cycle the op is accepted.
    always_comb begin
        stall_req = 1'b0;
        if (rst_n) begin
            stall_req = (r_state == DIV_BUSY) || w_accept;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_is_rem <= 1'b0;
            r_done   <= 1'b0;
            r_rd     <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_rd <= rd_in;
                if (w_special) begin
                    r_result <= w_spec_res;
                    r_done   <= 1'b1;
                end else begin
                    r_rem    <= '0;
                    r_quo    <= w_abs_a;
                    r_div    <= w_abs_b;
                    r_cnt    <= CNT_W'(XLEN - 1);
                    r_sign_q <= w_signed && (a[XLEN-1] ^ b[XLEN-1]);
                    r_sign_r <= w_signed && a[XLEN-1];
                    r_is_rem <= op_is_rem(op);
                end
            end else if ((r_state == DIV_BUSY) && !kill) begin
                r_rem <= w_step_rem;
                r_quo <= w_step_quo;
                if (w_last) begin
                    r_result <= r_is_rem ? w_rem_fin : w_quo_fin;
                    r_done   <= 1'b1;
                end else begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
            end
        end
    end

    assign done   = r_done;
    assign result = r_result;
    assign rd_out = r_rd;

endmodule

// File: tb/tb_div_unit_iter.sv
// Directed-vector bench for div_unit_iter: normal, signed, special-case, kill,
// mid-op reset and back-to-back operation with hand-computed expectations.
module tb_div_unit_iter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd_in;
    logic        kill;
    logic        stall_req;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_cmp = 0;
    int n_bad = 0;

    div_unit_iter #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .rd_in     (rd_in),
        .kill      (kill),
        .stall_req (stall_req),
        .done      (done),
        .result    (result),
        .rd_out    (rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present an op in the cycle after the next rising edge (cycle 0), return at its negedge.
    task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                            input logic [4:0] r);
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        rd_in = r;
        @(negedge clk);
    endtask

    // Count cycles from the accepting edge until done; cyc = -1 on timeout.
    task automatic run_to_done(input int budget, input bit hold, output int cyc, output int stalls);
        cyc    = -1;
        stalls = 0;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (stall_req === 1'b1) stalls++;
            if (done === 1'b1) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        rd_in = '0;
        kill  = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (stall_req !== 1'b0) begin n_bad++; $display("FAIL reset_stall got=%b exp=0", stall_req); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", done); end
        n_cmp++; if (result !== 32'h0) begin n_bad++; $display("FAIL reset_result got=%h exp=0", result); end
        n_cmp++; if (rd_out !== 5'd0) begin n_bad++; $display("FAIL reset_rd got=%0d exp=0", rd_out); end
        rst_n = 1'b1;
    endtask

    task automatic test_divu();
        int cyc, st;
        start_op(2'b01, 32'd100, 32'd7, 5'd5);
        n_cmp++; if (stall_req !== 1'b1) begin n_bad++; $display("FAIL divu_stall_c0 got=%b exp=1", stall_req); end
        run_to_done(40, 1'b0, cyc, st);
        n_cmp++; if (cyc !== 33) begin n_bad++; $display("FAIL divu_latency got=%0d exp=33", cyc); end
        n_cmp++; if (st !== 32) begin n_bad++; $display("FAIL divu_stall_cycles got=%0d exp=32", st); end
        n_cmp++; if (result !== 32'd14) begin n_bad++; $display("FAIL divu_result got=%h exp=%h", result, 32'd14); end
        n_cmp++; if (rd_out !== 5'd5) begin n_bad++; $display("FAIL divu_rd got=%0d exp=5", rd_out); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL divu_done_width got=%b exp=0", done); end
    endtask

    task automatic test_signed();
        logic [1:0]  v_op [6] = '{2'b00, 2'b10, 2'b11, 2'b00, 2'b10, 2'b01};
        logic [31:0] v_a  [6] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'd7, 32'hFFFFFFFF};
        logic [31:0] v_b  [6] = '{32'd2, 32'd2, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd1};
        logic [31:0] v_r  [6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFD, 32'd1, 32'hFFFFFFFF};
        int cyc, st;
        for (int i = 0; i < 6; i++) begin
            start_op(v_op[i], v_a[i], v_b[i], 5'(i + 1));
            run_to_done(40, 1'b0, cyc, st);
            n_cmp++; if (cyc !== 33) begin n_bad++; $display("FAIL signed_latency[%0d] got=%0d exp=33", i, cyc); end
            n_cmp++; if (result !== v_r[i]) begin n_bad++; $display("FAIL signed_result[%0d] got=%h exp=%h", i, result, v_r[i]); end
        end
    endtask

    task automatic test_special();
        logic [1:0]  v_op [4] = '{2'b00, 2'b10, 2'b00, 2'b10};
        logic [31:0] v_a  [4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
        logic [31:0] v_b  [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] v_r  [4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
        int cyc, st;
        for (int i = 0; i < 4; i++) begin
            start_op(v_op[i], v_a[i], v_b[i], 5'(i + 10));
            n_cmp++; if (stall_req !== 1'b1) begin n_bad++; $display("FAIL special_stall_c0[%0d] got=%b exp=1", i, stall_req); end
            run_to_done(40, 1'b0, cyc, st);
            n_cmp++; if (cyc !== 1) begin n_bad++; $display("FAIL special_latency[%0d] got=%0d exp=1", i, cyc); end
            n_cmp++; if (st !== 0) begin n_bad++; $display("FAIL special_stall_c1[%0d] got=%0d exp=0", i, st); end
            n_cmp++; if (result !== v_r[i]) begin n_bad++; $display("FAIL special_result[%0d] got=%h exp=%h", i, result, v_r[i]); end
        end
        // Same bit pattern unsigned is an ordinary divide.
        start_op(2'b01, 32'h80000000, 32'hFFFFFFFF, 5'd14);
        run_to_done(40, 1'b0, cyc, st);
        n_cmp++; if (cyc !== 33) begin n_bad++; $display("FAIL divu_big_latency got=%0d exp=33", cyc); end
        n_cmp++; if (result !== 32'd0) begin n_bad++; $display("FAIL divu_big_result got=%h exp=0", result); end
    endtask

    task automatic test_kill();
        int cyc, st;
        bit saw_done;
        start_op(2'b00, 32'd5, 32'd0, 5'd3);
        run_to_done(40, 1'b0, cyc, st);
        start_op(2'b01, 32'd1000, 32'd3, 5'd7);
        saw_done = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) start = 1'b0;
            if (c == 10) kill = 1'b1;
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        @(posedge clk);
        #1;
        kill = 1'b0;
        #1;
        n_cmp++; if (stall_req !== 1'b0) begin n_bad++; $display("FAIL kill_stall_c11 got=%b exp=0", stall_req); end
        n_cmp++; if (saw_done !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL kill_no_done got=%b/%b exp=0/0", saw_done, done); end
        n_cmp++; if (result !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL kill_result_held got=%h exp=ffffffff", result); end
        start = 1'b1;
        op    = 2'b01;
        a     = 32'd1000;
        b     = 32'd3;
        rd_in = 5'd8;
        @(negedge clk);
        n_cmp++; if (stall_req !== 1'b1) begin n_bad++; $display("FAIL kill_restart_stall got=%b exp=1", stall_req); end
        run_to_done(40, 1'b0, cyc, st);
        n_cmp++; if (cyc !== 33) begin n_bad++; $display("FAIL kill_restart_latency got=%0d exp=33", cyc); end
        n_cmp++; if (result !== 32'd333) begin n_bad++; $display("FAIL kill_restart_result got=%h exp=%h", result, 32'd333); end
        n_cmp++; if (rd_out !== 5'd8) begin n_bad++; $display("FAIL kill_restart_rd got=%0d exp=8", rd_out); end
    endtask

    task automatic test_reset_mid();
        int cyc, st;
        bit saw_done;
        start_op(2'b00, 32'd50, 32'd5, 5'd9);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (stall_req !== 1'b0) begin n_bad++; $display("FAIL rstmid_stall got=%b exp=0", stall_req); end
        n_cmp++; if (result !== 32'h0) begin n_bad++; $display("FAIL rstmid_result got=%h exp=0", result); end
        n_cmp++; if (rd_out !== 5'd0) begin n_bad++; $display("FAIL rstmid_rd got=%0d exp=0", rd_out); end
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0) saw_done = 1'b1;
        end
        n_cmp++; if (saw_done !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_done got=%b exp=0", saw_done); end
        rst_n = 1'b1;
        start_op(2'b00, 32'd50, 32'd5, 5'd9);
        run_to_done(40, 1'b0, cyc, st);
        n_cmp++; if (cyc !== 33) begin n_bad++; $display("FAIL rstmid_after_latency got=%0d exp=33", cyc); end
        n_cmp++; if (result !== 32'd10) begin n_bad++; $display("FAIL rstmid_after_result got=%h exp=%h", result, 32'd10); end
    endtask

    task automatic test_back_to_back();
        int cyc1, cyc2, st;
        start_op(2'b01, 32'd100, 32'd7, 5'd20);
        run_to_done(40, 1'b1, cyc1, st);
        n_cmp++; if (cyc1 !== 33) begin n_bad++; $display("FAIL b2b_first_latency got=%0d exp=33", cyc1); end
        n_cmp++; if (result !== 32'd14) begin n_bad++; $display("FAIL b2b_first_result got=%h exp=%h", result, 32'd14); end
        start_op(2'b00, 32'hFFFFFF9C, 32'd7, 5'd21);
        run_to_done(40, 1'b0, cyc2, st);
        n_cmp++; if (cyc1 + 1 + cyc2 !== 67) begin n_bad++; $display("FAIL b2b_second_cycle got=%0d exp=67", cyc1 + 1 + cyc2); end
        n_cmp++; if (result !== 32'hFFFFFFF2) begin n_bad++; $display("FAIL b2b_second_result got=%h exp=fffffff2", result); end
        n_cmp++; if (rd_out !== 5'd21) begin n_bad++; $display("FAIL b2b_second_rd got=%0d exp=21", rd_out); end
    endtask

    initial begin
        test_reset();
        test_divu();
        test_signed();
        test_special();
        test_kill();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
